// File: rtl/emif_writeback_if.sv
// ----------------------------------------------------------------------------
// emif_writeback_if
//   Groups the emif_writeback control, buffer-read and EMIF-write signals.
//   slave  : the writeback engine's view (drives buffer read + EMIF write).
//   master : the environment's view (layer FSM, buffer, EMIF).
//
//   start        layer FSM -> engine   begin a drain
//   base_addr    layer FSM -> engine   first EMIF word address
//   num_words    layer FSM -> engine   buffer words to drain
//   buf_addr     engine -> buffer      read address
//   buf_re       engine -> buffer      read enable
//   buf_data     buffer -> engine      read data, combinational from buf_addr
//   emif_address engine -> EMIF        write address
//   emif_datain  engine -> EMIF        write data
//   emif_wen     engine -> EMIF        write enable
//   busy / done  engine -> layer FSM   status
// ----------------------------------------------------------------------------
interface emif_writeback_if #(
    parameter int BUF_ADDR_WIDTH  = 8,
    parameter int BUF_DATA_WIDTH  = 16,
    parameter int EMIF_ADDR_WIDTH = 14,
    parameter int EMIF_DATA_WIDTH = 128
) ();
    logic                       start;
    logic [EMIF_ADDR_WIDTH-1:0] base_addr;
    logic [BUF_ADDR_WIDTH:0]    num_words;
    logic [BUF_ADDR_WIDTH-1:0]  buf_addr;
    logic                       buf_re;
    logic [BUF_DATA_WIDTH-1:0]  buf_data;
    logic [EMIF_ADDR_WIDTH-1:0] emif_address;
    logic [EMIF_DATA_WIDTH-1:0] emif_datain;
    logic                       emif_wen;
    logic                       busy;
    logic                       done;

    modport slave (
        input  start, base_addr, num_words, buf_data,
        output buf_addr, buf_re, emif_address, emif_datain, emif_wen, busy, done
    );

    modport master (
        output start, base_addr, num_words, buf_data,
        input  buf_addr, buf_re, emif_address, emif_datain, emif_wen, busy, done
    );
endinterface

// File: rtl/emif_writeback.sv
// ----------------------------------------------------------------------------
// emif_writeback
//   Drains num_words narrow words from an on-chip buffer (combinational read)
//   and packs them little-endian into wide EMIF words, written to consecutive
//   EMIF addresses starting at base_addr. Pulses done when finished.
//
//   Ports:
//     clk    clock
//     reset  asynchronous active-high reset
//     bus    emif_writeback_if.slave (start/base_addr/num_words in,
//            buffer read port, EMIF write port, busy/done out)
//
//   Flow: IDLE -> GATHER (one cycle per buffer word) -> WRITE (one cycle per
//   EMIF word) -> ... -> DONE (one-cycle pulse) -> IDLE.
//   All outputs decode from registered state only, so reset drops emif_wen
//   asynchronously and start has no combinational path to any output.
// ----------------------------------------------------------------------------
module emif_writeback #(
    parameter int BUF_ADDR_WIDTH  = 8,
    parameter int BUF_DATA_WIDTH  = 16,
    parameter int EMIF_ADDR_WIDTH = 14,
    parameter int EMIF_DATA_WIDTH = 128
) (
    input logic             clk,
    input logic             reset,
    emif_writeback_if.slave bus
);
    localparam int PACK   = EMIF_DATA_WIDTH / BUF_DATA_WIDTH;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W  = BUF_ADDR_WIDTH + 1;

    // Largest drain length the buffer can hold: 2^BUF_ADDR_WIDTH words.
    localparam logic [CNT_W-1:0]  MAX_N     = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                     state_q,  state_d;
    logic [EMIF_ADDR_WIDTH-1:0] base_q,   base_d;
    logic [CNT_W-1:0]           n_q,      n_d;
    logic [CNT_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]          lane_q,   lane_d;
    logic [EMIF_ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [EMIF_DATA_WIDTH-1:0] pack_q,   pack_d;

    logic [CNT_W-1:0]           n_clamped;

    assign n_clamped = (bus.num_words > MAX_N) ? MAX_N : bus.num_words;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        rd_ptr_d = rd_ptr_q;
        lane_d   = lane_q;
        wr_idx_d = wr_idx_q;
        pack_d   = pack_q;

        bus.buf_addr     = '0;
        bus.buf_re       = 1'b0;
        bus.emif_address = '0;
        bus.emif_datain  = '0;
        bus.emif_wen     = 1'b0;
        bus.busy         = (state_q != IDLE);
        bus.done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d   = bus.base_addr;
                    n_d      = n_clamped;
                    rd_ptr_d = '0;
                    lane_d   = '0;
                    wr_idx_d = '0;
                    pack_d   = '0;
                    state_d  = (n_clamped != '0) ? GATHER : DONE;
                end
            end

            GATHER: begin
                bus.buf_re   = 1'b1;
                bus.buf_addr = rd_ptr_q[BUF_ADDR_WIDTH-1:0];
                // Steer the read word into its lane; lane 0 holds the LSBs.
                for (int l = 0; l < PACK; l++) begin
                    if (lane_q == LANE_W'(l)) begin
                        pack_d[l*BUF_DATA_WIDTH +: BUF_DATA_WIDTH] = bus.buf_data;
                    end
                end
                rd_ptr_d = rd_ptr_q + CNT_W'(1);
                lane_d   = lane_q + LANE_W'(1);
                // Flush on a full pack word or on the last buffer word.
                if (lane_q == LAST_LANE || rd_ptr_q == n_q - CNT_W'(1)) begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                bus.emif_wen     = 1'b1;
                bus.emif_address = base_q + wr_idx_q;   // wraps mod 2^EMIF_ADDR_WIDTH
                bus.emif_datain  = pack_q;              // unfilled lanes already zero
                wr_idx_d = wr_idx_q + EMIF_ADDR_WIDTH'(1);
                lane_d   = '0;
                pack_d   = '0;
                state_d  = (rd_ptr_q == n_q) ? DONE : GATHER;
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            n_q      <= '0;
            rd_ptr_q <= '0;
            lane_q   <= '0;
            wr_idx_q <= '0;
            pack_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            rd_ptr_q <= rd_ptr_d;
            lane_q   <= lane_d;
            wr_idx_q <= wr_idx_d;
            pack_q   <= pack_d;
        end
    end
endmodule

// File: tb/tb_emif_writeback.sv
module tb_emif_writeback;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    emif_writeback_if bus ();
    emif_writeback dut (.clk(clk), .reset(reset), .bus(bus));

    logic [15:0] mem [0:255];
    assign bus.buf_data = mem[bus.buf_addr];

    typedef struct {
        logic [13:0]  addr;
        logic [127:0] data;
        int           cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    wr_t mon_e;
    int  mon_d;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int re_cnt = 0, wen_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every EMIF write and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (bus.buf_re) re_cnt++;
        if (bus.emif_wen) begin
            wen_cnt++;
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%h data=%h cycle=%0d expected no write",
                         bus.emif_address, bus.emif_datain, cyc);
            end else begin
                mon_e = wq.pop_front();
                check("wr_addr",  128'(bus.emif_address), 128'(mon_e.addr));
                check("wr_data",  bus.emif_datain, mon_e.data);
                check("wr_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
        if (bus.done) begin
            if (dq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual cycle=%0d expected no done", cyc);
            end else begin
                mon_d = dq.pop_front();
                check("done_cycle", 128'(cyc), 128'(mon_d));
            end
        end
    end

    task automatic push_wr(input logic [13:0] a, input logic [127:0] d, input int c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        wq.push_back(e);
    endtask

    // Called right after a negedge; the cycle-0 edge is the next posedge.
    task automatic pulse_start(input logic [13:0] base, input logic [8:0] n);
        bus.base_addr = base;
        bus.num_words = n;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
        check("pending_writes", 128'(wq.size()), 128'(0));
        check("pending_done",   128'(dq.size()), 128'(0));
        @(negedge clk);
        check("busy_after_done", 128'(bus.busy), 128'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     128'(bus.busy),         128'(0));
        check({tag, "_done"},     128'(bus.done),         128'(0));
        check({tag, "_wen"},      128'(bus.emif_wen),     128'(0));
        check({tag, "_re"},       128'(bus.buf_re),       128'(0));
        check({tag, "_buf_addr"}, 128'(bus.buf_addr),     128'(0));
        check({tag, "_addr"},     128'(bus.emif_address), 128'(0));
        check({tag, "_data"},     bus.emif_datain,        128'(0));
    endtask

    task automatic fill_seq(input logic [15:0] base_val, input int n);
        for (int i = 0; i < n; i++) mem[i] = base_val + 16'(i);
    endtask

    localparam logic [127:0] FULL_1000 = 128'h1007_1006_1005_1004_1003_1002_1001_1000;

    initial begin
        int t0, t1;
        logic [127:0] w;
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full word
        fill_seq(16'h1000, 8);
        wen_cnt = 0;
        t0 = cyc;
        push_wr(14'h0040, FULL_1000, t0 + 9);
        dq.push_back(t0 + 10);
        pulse_start(14'h0040, 9'd8);
        check("full_busy_c1", 128'(bus.busy), 128'(1));
        wait_drain(40);
        check("full_wen_count", 128'(wen_cnt), 128'(1));

        // Partial word: lanes 5..7 hold junk in the buffer but must write zero
        fill_seq(16'h00A0, 5);
        wen_cnt = 0;
        t0 = cyc;
        push_wr(14'h0123, 128'h0000_0000_0000_00A4_00A3_00A2_00A1_00A0, t0 + 6);
        dq.push_back(t0 + 7);
        pulse_start(14'h0123, 9'd5);
        wait_drain(40);
        check("partial_wen_count", 128'(wen_cnt), 128'(1));

        // Multi-word with address wrap
        fill_seq(16'h2000, 16);
        wen_cnt = 0;
        t0 = cyc;
        push_wr(14'h3FFF, 128'h2007_2006_2005_2004_2003_2002_2001_2000, t0 + 9);
        push_wr(14'h0000, 128'h200F_200E_200D_200C_200B_200A_2009_2008, t0 + 18);
        dq.push_back(t0 + 19);
        pulse_start(14'h3FFF, 9'd16);
        wait_drain(60);
        check("wrap_wen_count", 128'(wen_cnt), 128'(2));

        // Zero length
        wen_cnt = 0;
        re_cnt  = 0;
        t0 = cyc;
        dq.push_back(t0 + 1);
        pulse_start(14'h0055, 9'd0);
        check("zero_busy_c1", 128'(bus.busy), 128'(1));
        @(negedge clk);
        check("zero_busy_c2", 128'(bus.busy), 128'(0));
        wait_drain(10);
        check("zero_re_count",  128'(re_cnt),  128'(0));
        check("zero_wen_count", 128'(wen_cnt), 128'(0));

        // Reset mid-transfer, then a clean rerun
        fill_seq(16'h1000, 8);
        wen_cnt = 0;
        t0 = cyc;
        pulse_start(14'h0040, 9'd8);
        wait_cyc(t0 + 4);
        check("midrst_re_before", 128'(bus.buf_re), 128'(1));
        reset = 1'b1;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_wen_count", 128'(wen_cnt), 128'(0));
        check("midrst_pending_done", 128'(dq.size()), 128'(0));
        t0 = cyc;
        push_wr(14'h0050, FULL_1000, t0 + 9);
        dq.push_back(t0 + 10);
        pulse_start(14'h0050, 9'd8);
        wait_drain(40);
        check("rerun_wen_count", 128'(wen_cnt), 128'(1));

        // Start while busy: pulses in cycles 3 and 10 ignored, cycle 11 accepted
        wen_cnt = 0;
        t0 = cyc;
        push_wr(14'h0100, FULL_1000, t0 + 9);
        dq.push_back(t0 + 10);
        pulse_start(14'h0100, 9'd8);
        wait_cyc(t0 + 3);
        pulse_start(14'h0200, 9'd1);
        wait_cyc(t0 + 10);
        bus.base_addr = 14'h0200;
        bus.num_words = 9'd1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t1 = cyc;
        push_wr(14'h0300, 128'h1001_1000, t1 + 3);
        dq.push_back(t1 + 4);
        pulse_start(14'h0300, 9'd2);
        wait_drain(40);
        check("busy_start_wen_count", 128'(wen_cnt), 128'(2));

        // Length clamp: 300 requests drain the whole 256-word buffer
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        wen_cnt = 0;
        t0 = cyc;
        for (int k = 0; k < 32; k++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(8*k + j);
            push_wr(14'h0200 + 14'(k), w, t0 + 9*(k+1));
        end
        dq.push_back(t0 + 289);
        pulse_start(14'h0200, 9'd300);
        wait_drain(400);
        check("clamp_wen_count", 128'(wen_cnt), 128'(32));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
